// File: rtl/al_commit_reader.sv
// al_commit_reader
//   Commit-side reader of the active-list ready-bit RAM. Each cycle it reads up
//   to COMMIT_WIDTH consecutive entries starting at the head, retires the
//   oldest contiguous run of ready, non-excepting entries, clears their ready
//   bits through the commit write ports and advances the head. An excepting
//   entry at the head raises a one-cycle exception request and holds commit
//   until the pipeline flush completes; the faulting entry is then cleared
//   and skipped.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   alCount_i       occupied active-list entries (0..DEPTH)
//   stall_i         commit inhibit; blocks commit and exception detection
//   rdAddr_o        combinational read addresses, lane i = head+i (mod DEPTH)
//   rdData_i        same-cycle ready-RAM data per lane {excpt, ready}
//   clrAddr_o       registered clear-write addresses
//   clrData_o       clear-write data (always 0)
//   clrWe_o         registered clear-write enables
//   commitVec_o     registered per-lane commit pulse (thermometer from lane 0)
//   commitCnt_o     registered popcount of commitVec_o
//   headPtr_o       current head index
//   excpt_o         one-cycle exception request
//   excptAlId_o     head index of the excepting entry, valid with excpt_o
//   flushDone_i     pipeline flush complete; releases the exception hold
//
// Optional feature (macro AL_COMMIT_STATS_EN)
//   statCommitted_o  saturating cumulative count of committed entries
//   statStallCyc_o   saturating count of RUN cycles with entries but no commit

module al_commit_reader #(
  parameter int COMMIT_WIDTH = 4,
  parameter int DEPTH        = 128,
  parameter int INDEX        = 7,
  parameter int WIDTH        = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [INDEX:0]                         alCount_i,
  input  logic                                   stall_i,
  output logic [COMMIT_WIDTH*INDEX-1:0]          rdAddr_o,
  input  logic [COMMIT_WIDTH*WIDTH-1:0]          rdData_i,
  output logic [COMMIT_WIDTH*INDEX-1:0]          clrAddr_o,
  output logic [COMMIT_WIDTH*WIDTH-1:0]          clrData_o,
  output logic [COMMIT_WIDTH-1:0]                clrWe_o,
  output logic [COMMIT_WIDTH-1:0]                commitVec_o,
  output logic [$clog2(COMMIT_WIDTH+1)-1:0]      commitCnt_o,
  output logic [INDEX-1:0]                       headPtr_o,
  output logic                                   excpt_o,
  output logic [INDEX-1:0]                       excptAlId_o,
  input  logic                                   flushDone_i
`ifdef AL_COMMIT_STATS_EN
  ,
  output logic [31:0]                            statCommitted_o,
  output logic [31:0]                            statStallCyc_o
`endif
);

  localparam int CNT_W = $clog2(COMMIT_WIDTH+1);
  localparam int SUM_W = INDEX + 1;
  localparam int unsigned DEPTH_MASK = DEPTH - 1;

  typedef enum logic {RUN, EXCPT_WAIT} state_t;

  // Modulo-DEPTH wrap of an index sum (DEPTH is a power of two).
  function automatic logic [INDEX-1:0] wrap_idx(input logic [SUM_W-1:0] sum);
    return INDEX'(sum & SUM_W'(DEPTH_MASK));
  endfunction

  state_t             state_p1;
  logic [INDEX-1:0]   head_p1;
  logic [COMMIT_WIDTH-1:0] elig_p0;
  logic [CNT_W-1:0]   cnt_p0;
  logic               exc_p0;
  logic               chain_p0;

  assign headPtr_o = head_p1;
  assign clrData_o = '0;

  // Stage p0: combinational read window and lane selection
  always_comb begin
    rdAddr_o = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      rdAddr_o[i*INDEX +: INDEX] = wrap_idx({1'b0, head_p1} + SUM_W'(i));
    end
  end

  // A lane is eligible only while every older lane is: the chain bit drops at
  // the first unoccupied, not-ready or excepting lane, which yields a
  // thermometer-coded vector and truncates runs at a younger exception.
  always_comb begin
    elig_p0  = '0;
    cnt_p0   = '0;
    chain_p0 = (state_p1 == RUN) && !stall_i;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      chain_p0 = chain_p0 && (SUM_W'(i) < alCount_i) &&
                 rdData_i[i*WIDTH] && !rdData_i[i*WIDTH+1];
      elig_p0[i] = chain_p0;
      if (chain_p0) cnt_p0 = cnt_p0 + CNT_W'(1);
    end
  end

  assign exc_p0 = (state_p1 == RUN) && !stall_i && (alCount_i != '0) &&
                  rdData_i[0] && rdData_i[1];

  // Stage p1: registered commit, clear and exception outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1    <= RUN;
      head_p1     <= '0;
      commitVec_o <= '0;
      commitCnt_o <= '0;
      clrWe_o     <= '0;
      clrAddr_o   <= '0;
      excpt_o     <= 1'b0;
      excptAlId_o <= '0;
    end else begin
      commitVec_o <= '0;
      commitCnt_o <= '0;
      clrWe_o     <= '0;
      excpt_o     <= 1'b0;
      // Lane addresses follow the read window; lane 0 is the head, which is
      // also the faulting entry when leaving EXCPT_WAIT.
      clrAddr_o   <= rdAddr_o;
      case (state_p1)
        RUN: begin
          commitVec_o <= elig_p0;
          commitCnt_o <= cnt_p0;
          clrWe_o     <= elig_p0;
          head_p1     <= wrap_idx({1'b0, head_p1} + SUM_W'(cnt_p0));
          if (exc_p0) begin
            excpt_o     <= 1'b1;
            excptAlId_o <= head_p1;
            state_p1    <= EXCPT_WAIT;
          end
        end
        EXCPT_WAIT: begin
          if (flushDone_i) begin
            clrWe_o  <= COMMIT_WIDTH'(1);
            head_p1  <= wrap_idx({1'b0, head_p1} + SUM_W'(1));
            state_p1 <= RUN;
          end
        end
        default: state_p1 <= RUN;
      endcase
    end
  end

`ifdef AL_COMMIT_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      statCommitted_o <= '0;
      statStallCyc_o  <= '0;
    end else begin
      statCommitted_o <= sat_add(statCommitted_o, 32'(cnt_p0));
      if ((state_p1 == RUN) && (alCount_i != '0) && (cnt_p0 == '0))
        statStallCyc_o <= sat_add(statStallCyc_o, 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_al_commit_reader.sv
module tb_al_commit_reader;
  localparam int CW   = 4;
  localparam int IDX  = 7;
  localparam int W    = 2;
  localparam int CNTW = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [IDX:0]        alCount_i;
  logic                stall_i;
  logic [CW*IDX-1:0]   rdAddr_o;
  logic [CW*W-1:0]     rdData_i;
  logic [CW*IDX-1:0]   clrAddr_o;
  logic [CW*W-1:0]     clrData_o;
  logic [CW-1:0]       clrWe_o;
  logic [CW-1:0]       commitVec_o;
  logic [CNTW-1:0]     commitCnt_o;
  logic [IDX-1:0]      headPtr_o;
  logic                excpt_o;
  logic [IDX-1:0]      excptAlId_o;
  logic                flushDone_i;

  al_commit_reader #(.COMMIT_WIDTH(CW), .DEPTH(128), .INDEX(IDX), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .alCount_i(alCount_i), .stall_i(stall_i),
    .rdAddr_o(rdAddr_o), .rdData_i(rdData_i), .clrAddr_o(clrAddr_o),
    .clrData_o(clrData_o), .clrWe_o(clrWe_o), .commitVec_o(commitVec_o),
    .commitCnt_o(commitCnt_o), .headPtr_o(headPtr_o), .excpt_o(excpt_o),
    .excptAlId_o(excptAlId_o), .flushDone_i(flushDone_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]     vec;
    logic [CNTW-1:0]   cnt;
    logic [CW-1:0]     we;
    logic [CW*IDX-1:0] addr;
    logic [IDX-1:0]    head;
    logic              excpt;
    logic [IDX-1:0]    excid;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference state
  logic [IDX-1:0] m_head;
  logic           m_wait;
  logic [IDX-1:0] m_excid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_head = '0; m_wait = 1'b0; m_excid = '0;
  endtask

  // Drive one cycle of stimulus, predict the registered result, then compare.
  task automatic drive(input int cnt, input logic [CW-1:0] rdy, input logic [CW-1:0] exc,
                       input logic stall, input logic flush);
    exp_t e, g;
    logic ok;
    alCount_i   = (IDX+1)'(cnt);
    stall_i     = stall;
    flushDone_i = flush;
    for (int i = 0; i < CW; i++) begin
      rdData_i[i*W]   = rdy[i];
      rdData_i[i*W+1] = exc[i];
    end
    #1;
    for (int i = 0; i < CW; i++)
      chk($sformatf("rdAddr%0d", i), 32'(rdAddr_o[i*IDX +: IDX]), 32'(IDX'(m_head + IDX'(i))));
    e.vec = '0; e.cnt = '0; e.we = '0; e.excpt = 1'b0;
    e.addr = '0;
    for (int i = 0; i < CW; i++) e.addr[i*IDX +: IDX] = m_head + IDX'(i);
    if (!m_wait) begin
      if (!stall) begin
        ok = 1'b1;
        for (int i = 0; i < CW; i++) begin
          ok = ok && (i < cnt) && rdy[i] && !exc[i];
          e.vec[i] = ok;
          if (ok) e.cnt = e.cnt + 1'b1;
        end
        if (cnt > 0 && rdy[0] && exc[0]) begin
          e.excpt = 1'b1; m_excid = m_head; m_wait = 1'b1;
        end
      end
      e.we = e.vec;
      m_head = m_head + IDX'(e.cnt);
    end else if (flush) begin
      e.we = 4'b0001;
      m_head = m_head + 1'b1;
      m_wait = 1'b0;
    end
    e.head = m_head;
    e.excid = m_excid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("commitVec", 32'(commitVec_o), 32'(g.vec));
    chk("commitCnt", 32'(commitCnt_o), 32'(g.cnt));
    chk("clrWe", 32'(clrWe_o), 32'(g.we));
    chk("headPtr", 32'(headPtr_o), 32'(g.head));
    chk("excpt", 32'(excpt_o), 32'(g.excpt));
    if (g.excpt) chk("excptAlId", 32'(excptAlId_o), 32'(g.excid));
    for (int i = 0; i < CW; i++)
      if (g.we[i]) chk($sformatf("clrAddr%0d", i), 32'(clrAddr_o[i*IDX +: IDX]), 32'(g.addr[i*IDX +: IDX]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vec"}, 32'(commitVec_o), 32'd0);
    chk({tag, "_cnt"}, 32'(commitCnt_o), 32'd0);
    chk({tag, "_we"}, 32'(clrWe_o), 32'd0);
    chk({tag, "_addr"}, 32'(clrAddr_o), 32'd0);
    chk({tag, "_head"}, 32'(headPtr_o), 32'd0);
    chk({tag, "_excpt"}, 32'(excpt_o), 32'd0);
    chk({tag, "_excid"}, 32'(excptAlId_o), 32'd0);
    chk({tag, "_data"}, 32'(clrData_o), 32'd0);
  endtask

  initial begin
    reset = 1'b1; alCount_i = '0; stall_i = 1'b0; rdData_i = '0; flushDone_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    model_reset();

    // Empty list: nothing commits even with ready bits set
    for (int k = 0; k < 5; k++) drive(0, 4'b1111, 4'b0000, 1'b0, 1'b0);

    // Ready {1,1,0,1}: run stops at lane 2
    drive(8, 4'b1011, 4'b0000, 1'b0, 1'b0);
    chk("tp_run_vec", 32'(commitVec_o), 32'b0011);
    chk("tp_run_head", 32'(headPtr_o), 32'd2);

    // Advance to head 126, then commit across the wrap
    for (int k = 0; k < 31; k++) drive(8, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk("tp_pre_wrap_head", 32'(headPtr_o), 32'd126);
    drive(4, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk("tp_wrap_vec", 32'(commitVec_o), 32'b1111);
    chk("tp_wrap_addr", 32'(clrAddr_o), {4'd0, 7'd1, 7'd0, 7'd127, 7'd126});
    chk("tp_wrap_head", 32'(headPtr_o), 32'd2);

    // Partial occupancy, then the same with stall
    drive(2, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk("tp_partial_vec", 32'(commitVec_o), 32'b0011);
    drive(2, 4'b1111, 4'b0000, 1'b1, 1'b0);
    chk("tp_stall_vec", 32'(commitVec_o), 32'b0000);
    chk("tp_stall_head", 32'(headPtr_o), 32'd4);

    // Exception at head 10
    drive(8, 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive(2, 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive(8, 4'b0001, 4'b0001, 1'b0, 1'b0);
    chk("tp_exc_pulse", 32'(excpt_o), 32'd1);
    chk("tp_exc_id", 32'(excptAlId_o), 32'd10);
    for (int k = 0; k < 6; k++) drive(8, 4'b1111, 4'b0001, 1'b0, 1'b0);
    drive(8, 4'b1111, 4'b0001, 1'b0, 1'b1);
    chk("tp_flush_we", 32'(clrWe_o), 32'b0001);
    chk("tp_flush_addr", 32'(clrAddr_o[IDX-1:0]), 32'd10);
    chk("tp_flush_head", 32'(headPtr_o), 32'd11);
    drive(8, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk("tp_resume_head", 32'(headPtr_o), 32'd15);
    // flushDone in RUN has no effect; younger exception truncates the run
    drive(0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive(8, 4'b1111, 4'b0100, 1'b0, 1'b0);
    chk("tp_trunc_vec", 32'(commitVec_o), 32'b0011);

    // Reach head 40 and raise an exception there, then reset mid-wait
    for (int k = 0; k < 5; k++) drive(8, 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive(3, 4'b1111, 4'b0000, 1'b0, 1'b0);
    chk("tp_head40", 32'(headPtr_o), 32'd40);
    drive(8, 4'b0001, 4'b0001, 1'b0, 1'b0);
    drive(8, 4'b1111, 4'b0000, 1'b0, 1'b0);
    reset = 1'b1;
    alCount_i = 8'd8; rdData_i = 8'hFF; flushDone_i = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midwait_reset");
    reset = 1'b0;
    model_reset();
    drive(1, 4'b0001, 4'b0000, 1'b0, 1'b0);
    chk("tp_after_reset_vec", 32'(commitVec_o), 32'b0001);
    chk("tp_after_reset_head", 32'(headPtr_o), 32'd1);

    // Mixed pseudo-random traffic against the reference
    for (int k = 0; k < 60; k++) begin
      drive(int'($urandom_range(0, 8)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
